// File: rtl/cga_tty.sv
// Byte-stream terminal writer for the CGA text store (port b): prints characters, handles CR/LF/BS/FF, scrolls by copy.
// Optional: define CGA_TTY_CLEAR_ON_RESET_EN to run the full-screen clear automatically after reset release.
module cga_tty #(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 25,
  parameter logic [7:0]  BLANK_ATTR = 8'h07,
  parameter int          RD_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  attr,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy,
  output logic [12:0] mem_address,
  output logic [7:0]  mem_wdata,
  output logic        mem_wren,
  input  logic [7:0]  mem_rdata
);

  localparam logic [12:0] ROW_BYTES   = 13'(2 * COLS);
  localparam logic [12:0] COPY_LAST   = 13'(2 * COLS * (ROWS - 1) - 1);
  localparam logic [12:0] LAST_ROW    = 13'(2 * COLS * (ROWS - 1));
  localparam logic [12:0] SCREEN_LAST = 13'(2 * COLS * ROWS - 1);
  localparam logic [6:0]  COL_LAST    = 7'(COLS - 1);
  localparam logic [4:0]  ROW_LAST    = 5'(ROWS - 1);

  typedef enum logic [3:0] {
    IDLE, PUT_CHAR, PUT_ATTR, ADVANCE, SCR_RD, SCR_WAIT, SCR_WR, FILL_CHR, FILL_ATR
  } state_t;

  state_t      state, state_nx;
  logic [6:0]  col, col_nx;
  logic [4:0]  row, row_nx;
  logic [12:0] cnt, cnt_nx;
  logic [1:0]  wcnt, wcnt_nx;
  logic        clear_all, clear_nx;
  logic        accept;
  logic        lf;
  logic [7:0]  code, attr_q;
  logic [11:0] cell_idx;
  logic [12:0] cell_addr;
`ifdef CGA_TTY_CLEAR_ON_RESET_EN
  logic        init_pending, init_nx;
`endif

  function automatic logic is_ctrl(input logic [7:0] c);
    return (c == 8'h08) || (c == 8'h0A) || (c == 8'h0C) || (c == 8'h0D);
  endfunction

  assign cell_idx   = 12'({8'd0, row} * 13'(COLS) + {6'd0, col});
  assign cell_addr  = {cell_idx, 1'b0};
  assign cursor_col = col;
  assign cursor_row = row;
  assign busy       = !in_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      cnt       <= '0;
      wcnt      <= '0;
      clear_all <= 1'b0;
`ifdef CGA_TTY_CLEAR_ON_RESET_EN
      init_pending <= 1'b1;
`endif
    end else begin
      state     <= state_nx;
      col       <= col_nx;
      row       <= row_nx;
      cnt       <= cnt_nx;
      wcnt      <= wcnt_nx;
      clear_all <= clear_nx;
`ifdef CGA_TTY_CLEAR_ON_RESET_EN
      init_pending <= init_nx;
`endif
    end
  end

  // Byte and attribute are captured once at accept; later attr changes cannot leak in.
  always_ff @(posedge clock) begin
    if (accept) begin
      code   <= in_data;
      attr_q <= attr;
    end
  end

  always_comb begin
    state_nx    = state;
    col_nx      = col;
    row_nx      = row;
    cnt_nx      = cnt;
    wcnt_nx     = wcnt;
    clear_nx    = clear_all;
    in_ready    = 1'b0;
    accept      = 1'b0;
    lf          = 1'b0;
    mem_wren    = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
`ifdef CGA_TTY_CLEAR_ON_RESET_EN
    init_nx     = init_pending;
`endif
    unique case (state)
      IDLE: begin
`ifdef CGA_TTY_CLEAR_ON_RESET_EN
        if (init_pending) begin
          init_nx  = 1'b0;
          cnt_nx   = '0;
          clear_nx = 1'b1;
          state_nx = FILL_CHR;
        end else begin
`else
        begin
`endif
          in_ready = 1'b1;
          if (in_valid) begin
            accept   = 1'b1;
            state_nx = is_ctrl(in_data) ? ADVANCE : PUT_CHAR;
          end
        end
      end
      PUT_CHAR: begin
        mem_wren    = 1'b1;
        mem_address = cell_addr;
        mem_wdata   = code;
        state_nx    = PUT_ATTR;
      end
      PUT_ATTR: begin
        mem_wren    = 1'b1;
        mem_address = cell_addr + 13'd1;
        mem_wdata   = attr_q;
        state_nx    = ADVANCE;
      end
      ADVANCE: begin
        state_nx = IDLE;
        case (code)
          8'h0D: col_nx = '0;
          8'h08: if (col != '0) col_nx = col - 7'd1;
          8'h0A: lf = 1'b1;
          8'h0C: begin
            cnt_nx   = '0;
            clear_nx = 1'b1;
            state_nx = FILL_CHR;
          end
          default: begin
            if (col == COL_LAST) lf = 1'b1;
            else                 col_nx = col + 7'd1;
          end
        endcase
        if (lf) begin
          col_nx = '0;
          if (row != ROW_LAST) begin
            row_nx = row + 5'd1;
          end else begin
            cnt_nx   = '0;
            clear_nx = 1'b0;
            state_nx = SCR_RD;
          end
        end
      end
      SCR_RD: begin
        mem_address = cnt + ROW_BYTES;
        wcnt_nx     = '0;
        state_nx    = (RD_LATENCY > 1) ? SCR_WAIT : SCR_WR;
      end
      SCR_WAIT: begin
        mem_address = cnt + ROW_BYTES;
        if (int'(wcnt) >= RD_LATENCY - 2) state_nx = SCR_WR;
        else                              wcnt_nx  = wcnt + 2'd1;
      end
      SCR_WR: begin
        mem_wren    = 1'b1;
        mem_address = cnt;
        mem_wdata   = mem_rdata;
        if (cnt == COPY_LAST) begin
          cnt_nx   = LAST_ROW;
          state_nx = FILL_CHR;
        end else begin
          cnt_nx   = cnt + 13'd1;
          state_nx = SCR_RD;
        end
      end
      FILL_CHR: begin
        mem_wren    = 1'b1;
        mem_address = cnt;
        mem_wdata   = 8'h20;
        cnt_nx      = cnt + 13'd1;
        state_nx    = FILL_ATR;
      end
      FILL_ATR: begin
        mem_wren    = 1'b1;
        mem_address = cnt;
        mem_wdata   = BLANK_ATTR;
        if (cnt == SCREEN_LAST) begin
          state_nx = IDLE;
          if (clear_all) begin
            col_nx = '0;
            row_nx = '0;
          end
        end else begin
          cnt_nx   = cnt + 13'd1;
          state_nx = FILL_CHR;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cga_tty.sv
// Randomized bench for cga_tty: screen/cursor reference model plus a behavioural text-store memory on port b.
module tb_cga_tty;
  localparam int COLS       = 80;
  localparam int ROWS       = 25;
  localparam int SCR_BYTES  = 2 * COLS * ROWS;
  localparam int COPY_BYTES = 2 * COLS * (ROWS - 1);
  localparam int RD_LAT     = 1;
  localparam int BOUND      = 20000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  attr;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;
  logic [12:0] mem_address;
  logic [7:0]  mem_wdata;
  logic        mem_wren;
  logic [7:0]  mem_rdata;

  always #5 clock = ~clock;

  cga_tty #(.COLS(COLS), .ROWS(ROWS), .BLANK_ATTR(8'h07), .RD_LATENCY(RD_LAT)) dut (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .attr(attr), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .busy(busy), .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_rdata(mem_rdata)
  );

  // Text store port b with one cycle read latency, plus write/accept bookkeeping.
  logic [7:0]  mem [0:8191];
  logic        pl_en = 1'b0;
  logic [12:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;
  int          wr_count = 0, bad_addr = 0, acc_count = 0, cyc = 0;
  logic [12:0] last_addr = '0, prev_addr = '0;
  logic [7:0]  last_data = '0, prev_data = '0;
  int          last_cyc = 0, prev_cyc = 0;

  always @(posedge clock) begin
    cyc       <= cyc + 1;
    mem_rdata <= mem[mem_address];
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (mem_wren) begin
      mem[mem_address] <= mem_wdata;
      wr_count  <= wr_count + 1;
      if (int'(mem_address) >= SCR_BYTES) bad_addr <= bad_addr + 1;
      prev_addr <= last_addr;
      prev_data <= last_data;
      prev_cyc  <= last_cyc;
      last_addr <= mem_address;
      last_data <= mem_wdata;
      last_cyc  <= cyc;
    end
    if (in_valid && in_ready && reset_n) acc_count <= acc_count + 1;
  end

  // Reference model: expected screen bytes and cursor.
  logic [7:0] scr [0:SCR_BYTES-1];
  int ccol = 0, crow = 0;
  int n_checks = 0, n_fail = 0;
  int last_busy = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic model_apply(input logic [7:0] c, input logic [7:0] a,
                             output int exp_busy, output int exp_wr);
    bit do_lf;
    do_lf    = 1'b0;
    exp_busy = 1;
    exp_wr   = 0;
    case (c)
      8'h0D: ccol = 0;
      8'h08: if (ccol > 0) ccol--;
      8'h0A: do_lf = 1'b1;
      8'h0C: begin
        for (int i = 0; i < SCR_BYTES; i++) scr[i] = (i % 2 == 1) ? 8'h07 : 8'h20;
        ccol = 0; crow = 0;
        exp_busy = 1 + SCR_BYTES;
        exp_wr   = SCR_BYTES;
      end
      default: begin
        scr[2 * (crow * COLS + ccol)]     = c;
        scr[2 * (crow * COLS + ccol) + 1] = a;
        exp_busy = 3;
        exp_wr   = 2;
        if (ccol == COLS - 1) do_lf = 1'b1;
        else                  ccol++;
      end
    endcase
    if (do_lf) begin
      ccol = 0;
      if (crow < ROWS - 1) begin
        crow++;
      end else begin
        for (int i = 0; i < COPY_BYTES; i++) scr[i] = scr[i + 2 * COLS];
        for (int i = COPY_BYTES; i < SCR_BYTES; i++) scr[i] = (i % 2 == 1) ? 8'h07 : 8'h20;
        exp_busy += COPY_BYTES * (RD_LAT + 1) + 2 * COLS;
        exp_wr   += SCR_BYTES - COPY_BYTES + COPY_BYTES;
      end
    end
  endtask

  task automatic compare_screen(input string tag);
    int m;
    m = 0;
    for (int i = 0; i < SCR_BYTES; i++) if (mem[i] != scr[i]) m++;
    check(tag, m, 0);
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] a, input string tag);
    int exp_busy, exp_wr, wr0, n;
    n = 0;
    while (!in_ready && n < BOUND) begin @(negedge clock); n++; end
    if (!in_ready) check({tag, ".ready_timeout"}, 0, 1);
    model_apply(c, a, exp_busy, exp_wr);
    wr0 = wr_count;
    @(negedge clock);
    in_data  = c;
    attr     = a;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    attr     = 8'($urandom);
    in_data  = 8'($urandom);
    n = 0;
    while (!in_ready && n < BOUND) begin @(posedge clock); #1; n++; end
    last_busy = n;
    check({tag, ".busy_cycles"}, n, exp_busy);
    check({tag, ".writes"}, wr_count - wr0, exp_wr);
    check({tag, ".col"}, int'(cursor_col), ccol);
    check({tag, ".row"}, int'(cursor_row), crow);
    compare_screen({tag, ".screen"});
  endtask

  task automatic preload(input int a, input logic [7:0] d);
    @(negedge clock);
    pl_addr = 13'(a);
    pl_data = d;
    pl_en   = 1'b1;
    @(negedge clock);
    pl_en   = 1'b0;
    scr[a]  = d;
  endtask

  function automatic logic [7:0] rand_printable();
    logic [7:0] v;
    do v = 8'($urandom_range(0, 255));
    while (v == 8'h08 || v == 8'h0A || v == 8'h0C || v == 8'h0D);
    return v;
  endfunction

  initial begin
    int acc0, wr0, r;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; attr = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst.wren", int'(mem_wren), 0);
    check("rst.addr", int'(mem_address), 0);
    check("rst.wdata", int'(mem_wdata), 0);
    check("rst.ready", int'(in_ready), 1);
    check("rst.busy", int'(busy), 0);
    check("rst.col", int'(cursor_col), 0);
    check("rst.row", int'(cursor_row), 0);
    @(negedge clock) reset_n = 1'b1;
    #1 check("rel.ready", int'(in_ready), 1);

    send(8'h0C, 8'h00, "ff_init");
    check("ff_init.bad_addr", bad_addr, 0);

    send(8'h41, 8'h1E, "char_a");
    check("char_a.first_addr", int'(prev_addr), 0);
    check("char_a.first_data", int'(prev_data), 8'h41);
    check("char_a.second_addr", int'(last_addr), 1);
    check("char_a.second_data", int'(last_data), 8'h1E);
    check("char_a.consecutive", last_cyc - prev_cyc, 1);
    check("char_a.ready_low", last_busy, 3);

    for (int i = 0; i < 3; i++) send(8'h0A, 8'h00, "lf");
    for (int i = 0; i < COLS - 1; i++) send(rand_printable(), 8'($urandom), "fill_row");
    send(8'h5A, 8'h4F, "wrap_z");
    check("wrap_z.char_addr", int'(prev_addr), 638);
    check("wrap_z.attr_addr", int'(last_addr), 639);
    check("wrap_z.col", int'(cursor_col), 0);
    check("wrap_z.row", int'(cursor_row), 4);

    preload(160, 8'h55);
    preload(3999, 8'h99);
    while (crow < ROWS - 1) send(8'h0A, 8'h00, "lf_down");
    send(8'h0A, 8'h00, "scroll");
    check("scroll.addr0", int'(mem[0]), 8'h55);
    check("scroll.addr3998", int'(mem[3998]), 8'h20);
    check("scroll.addr3999", int'(mem[3999]), 8'h07);
    check("scroll.cycles", last_busy, 1 + 3840 * (RD_LAT + 1) + 160);
    check("scroll.row", int'(cursor_row), 24);

    send(8'h0C, 8'h00, "ff");
    check("ff.bad_addr", bad_addr, 0);
    for (int i = 0; i < 5; i++) send(8'h0A, 8'h00, "lf5");
    send(8'h08, 8'h00, "bs_col0");
    check("bs_col0.col", int'(cursor_col), 0);
    check("bs_col0.row", int'(cursor_row), 5);
    for (int i = 0; i < 10; i++) send(rand_printable(), 8'($urandom), "pr10");
    send(8'h08, 8'h00, "bs");
    send(rand_printable(), 8'($urandom), "pr");
    send(8'h0D, 8'h00, "cr");
    check("cr.col", int'(cursor_col), 0);

    for (int k = 0; k < 120; k++) begin
      r = $urandom_range(0, 99);
      if (r < 75)      send(rand_printable(), 8'($urandom), "rnd_char");
      else if (r < 83) send(8'h0D, 8'($urandom), "rnd_cr");
      else if (r < 91) send(8'h08, 8'($urandom), "rnd_bs");
      else if (r < 98) send(8'h0A, 8'($urandom), "rnd_lf");
      else             send(8'h0C, 8'($urandom), "rnd_ff");
    end
    check("rnd.bad_addr", bad_addr, 0);

    send(8'h0D, 8'h00, "pre_rst_cr");
    while (crow < ROWS - 1) send(8'h0A, 8'h00, "pre_rst_lf");
    while (ccol < COLS - 1) send(rand_printable(), 8'($urandom), "pre_rst_char");
    @(negedge clock);
    in_data  = 8'h42;
    attr     = 8'h17;
    in_valid = 1'b1;
    acc0     = acc_count;
    repeat (1000) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("midrst.wren", int'(mem_wren), 0);
    check("midrst.col", int'(cursor_col), 0);
    check("midrst.row", int'(cursor_row), 0);
    check("midrst.accepts", acc_count - acc0, 1);
    wr0 = wr_count;
    repeat (4) @(posedge clock);
    #1 check("midrst.no_writes", wr_count - wr0, 0);
    in_valid = 1'b0;
    @(negedge clock) reset_n = 1'b1;
    #1;
    check("postrst.ready", int'(in_ready), 1);
    check("postrst.busy", int'(busy), 0);
    check("postrst.addr", int'(mem_address), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
